// File: rtl/otter_pipe_ctrl_if.sv
// otter_pipe_ctrl_if: decode/execute hazard inputs and pipeline control outputs of the OTTER controller
interface otter_pipe_ctrl_if #(parameter int CNT_W = 32);
    logic [4:0]       DEC_RS1;
    logic [4:0]       DEC_RS2;
    logic             DEC_USE_RS1;
    logic             DEC_USE_RS2;
    logic [4:0]       EX_RD;
    logic             EX_REG_WRITE;
    logic             EX_MEM_READ;
    logic             EX_BR_TAKEN;
    logic             INT_REQ;
    logic             PC_WRITE;
    logic             DEC_EN;
    logic             DEC_FLUSH;
    logic             EX_FLUSH;
    logic             TRAP_SEL;
    logic             MEPC_CAPTURE;
    logic             INT_TAKEN;
    logic [CNT_W-1:0] STALL_COUNT;

    modport master (
        output DEC_RS1, DEC_RS2, DEC_USE_RS1, DEC_USE_RS2, EX_RD, EX_REG_WRITE,
               EX_MEM_READ, EX_BR_TAKEN, INT_REQ,
        input  PC_WRITE, DEC_EN, DEC_FLUSH, EX_FLUSH, TRAP_SEL, MEPC_CAPTURE,
               INT_TAKEN, STALL_COUNT
    );

    modport slave (
        input  DEC_RS1, DEC_RS2, DEC_USE_RS1, DEC_USE_RS2, EX_RD, EX_REG_WRITE,
               EX_MEM_READ, EX_BR_TAKEN, INT_REQ,
        output PC_WRITE, DEC_EN, DEC_FLUSH, EX_FLUSH, TRAP_SEL, MEPC_CAPTURE,
               INT_TAKEN, STALL_COUNT
    );
endinterface

// File: rtl/otter_pipe_ctrl.sv
// otter_pipe_ctrl: load-use stall, branch flush and interrupt drain/redirect sequencing for the OTTER pipeline
module otter_pipe_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input logic              CLK,
    input logic              RST,
    otter_pipe_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, DRAIN, TRAP} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             holdoff_q, holdoff_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic             luh;
    logic             pc_write, dec_en, dec_flush, ex_flush, trap_sel, mepc_capture, int_taken;

    assign luh = bus.EX_MEM_READ && bus.EX_REG_WRITE && (bus.EX_RD != 5'd0) &&
                 ((bus.DEC_USE_RS1 && (bus.DEC_RS1 == bus.EX_RD)) ||
                  (bus.DEC_USE_RS2 && (bus.DEC_RS2 == bus.EX_RD)));

    // Next state and Mealy control outputs; reset forces the bubble-everything outputs
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        holdoff_d     = holdoff_q;
        stall_count_d = stall_count_q;
        pc_write      = 1'b0;
        dec_en        = 1'b0;
        dec_flush     = 1'b0;
        ex_flush      = 1'b1;
        trap_sel      = 1'b0;
        mepc_capture  = 1'b0;
        int_taken     = 1'b0;
        case (state_q)
            RUN: begin
                holdoff_d = 1'b0;
                if (bus.EX_BR_TAKEN) begin
                    pc_write  = 1'b1;
                    dec_en    = 1'b1;
                    dec_flush = 1'b1;
                end else if (bus.INT_REQ && !holdoff_q) begin
                    mepc_capture = 1'b1;
                    cnt_d        = 4'(DRAIN_CYCLES - 1);
                    state_d      = DRAIN;
                end else if (luh) begin
                    stall_count_d = stall_count_q + 1'b1;
                end else begin
                    pc_write = 1'b1;
                    dec_en   = 1'b1;
                    ex_flush = 1'b0;
                end
            end
            DRAIN: begin
                state_d = (cnt_q == 4'd0) ? TRAP : DRAIN;
                cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
            end
            TRAP: begin
                pc_write  = 1'b1;
                dec_en    = 1'b1;
                dec_flush = 1'b1;
                trap_sel  = 1'b1;
                int_taken = 1'b1;
                holdoff_d = 1'b1;
                state_d   = RUN;
            end
            default: state_d = RUN;
        endcase
        if (RST) begin
            pc_write     = 1'b0;
            dec_en       = 1'b0;
            dec_flush    = 1'b1;
            ex_flush     = 1'b1;
            trap_sel     = 1'b0;
            mepc_capture = 1'b0;
            int_taken    = 1'b0;
        end
    end

    // State, drain counter, holdoff flag and stall counter registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= RUN;
            cnt_q         <= 4'd0;
            holdoff_q     <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            holdoff_q     <= holdoff_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.PC_WRITE     = pc_write;
    assign bus.DEC_EN       = dec_en;
    assign bus.DEC_FLUSH    = dec_flush;
    assign bus.EX_FLUSH     = ex_flush;
    assign bus.TRAP_SEL     = trap_sel;
    assign bus.MEPC_CAPTURE = mepc_capture;
    assign bus.INT_TAKEN    = int_taken;
    assign bus.STALL_COUNT  = stall_count_q;
endmodule
